// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared widths and sequencer state encoding for the dot-product slice
package vec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        OUT
    } seq_state_e;

    function automatic int w_y(input int c, input int w_x, input int w_k);
        return w_x + w_k + $clog2(c);
    endfunction

    function automatic int w_a(input int c, input int w_x, input int w_k, input int max_chunks);
        return w_y(c, w_x, w_k) + $clog2(max_chunks);
    endfunction

endpackage

// File: rtl/vec_dot_seq_if.sv
// rtl/vec_dot_seq_if.sv - operand chunk stream in, dot-product result stream out
interface vec_dot_seq_if
    import vec_pkg::*;
#(
    parameter int C          = 4,
    parameter int W_X        = 8,
    parameter int W_K        = 8,
    parameter int MAX_CHUNKS = 16,
    parameter int W_A        = w_a(C, W_X, W_K, MAX_CHUNKS)
) ();

    logic                   s_valid;
    logic                   s_ready;
    logic [C-1:0][W_X-1:0]  s_x;
    logic [C-1:0][W_K-1:0]  s_k;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [W_A-1:0]         m_y;
    logic                   m_overflow;

    modport master (
        output s_valid, s_x, s_k, s_last, m_ready,
        input  s_ready, m_valid, m_y, m_overflow
    );

    modport slave (
        input  s_valid, s_x, s_k, s_last, m_ready,
        output s_ready, m_valid, m_y, m_overflow
    );

endinterface

// File: rtl/vec_mul.sv
// rtl/vec_mul.sv - pipelined C-lane signed multiply and adder tree, latency $clog2(C)+1
module vec_mul
    import vec_pkg::*;
#(
    parameter int C   = 4,
    parameter int W_X = 8,
    parameter int W_K = 8,
    parameter int W_Y = w_y(C, W_X, W_K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [C-1:0][W_X-1:0] x,
    input  logic [C-1:0][W_K-1:0] k,
    output logic [W_Y-1:0]        y_out
);

    logic signed [W_Y-1:0] xe   [C];
    logic signed [W_Y-1:0] ke   [C];
    logic signed [W_Y-1:0] prod [C];
    // Heap-ordered tree: leaves C-1..2C-2 hold products, node n sums 2n+1 and 2n+2.
    logic signed [W_Y-1:0] node [2*C-1];

    always_comb begin
        for (int n = 0; n < C; n++) begin
            xe[n]   = {{(W_Y-W_X){x[n][W_X-1]}}, x[n]};
            ke[n]   = {{(W_Y-W_K){k[n][W_K-1]}}, k[n]};
            prod[n] = xe[n] * ke[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2*C-1; n++) node[n] <= '0;
        end else if (enable) begin
            for (int n = 0; n < C; n++) node[C-1+n] <= prod[n];
            for (int n = 0; n < C-1; n++) node[n] <= node[2*n+1] + node[2*n+2];
        end
    end

    assign y_out = node[0];

endmodule

// File: rtl/vec_dot_seq.sv
// rtl/vec_dot_seq.sv - sequences operand chunks through vec_mul and accumulates one result per vector
module vec_dot_seq
    import vec_pkg::*;
#(
    parameter int C          = 4,
    parameter int W_X        = 8,
    parameter int W_K        = 8,
    parameter int MAX_CHUNKS = 16,
    parameter int PE_LATENCY = $clog2(C) + 1
) (
    input  logic          clk,
    input  logic          rst,
    vec_dot_seq_if.slave  bus
);

    localparam int W_Y = w_y(C, W_X, W_K);
    localparam int W_A = w_a(C, W_X, W_K, MAX_CHUNKS);
    localparam int CW  = $clog2(MAX_CHUNKS) + 1;

    seq_state_e             state, state_nx;
    logic                   accept, pe_en, trunc;
    logic [CW-1:0]          count, count_nx;
    logic [PE_LATENCY-1:0]  vld_sr;
    logic signed [W_A-1:0]  acc, y_ext, res_y;
    logic                   res_valid, ovf;
    logic [C-1:0][W_X-1:0]  pe_x;
    logic [C-1:0][W_K-1:0]  pe_k;
    logic [W_Y-1:0]         y_out;

    assign bus.s_ready = !rst && (state == IDLE || state == FEED);
    assign accept      = bus.s_valid && bus.s_ready;
    assign pe_en       = (state != OUT);
    assign pe_x        = accept ? bus.s_x : '0;
    assign pe_k        = accept ? bus.s_k : '0;
    assign count_nx    = (state == IDLE) ? CW'(1) : count + 1'b1;
    // Reaching the chunk limit without s_last closes the vector and flags truncation.
    assign trunc       = accept && !bus.s_last && (count_nx == CW'(MAX_CHUNKS));
    assign y_ext       = {{(W_A-W_Y){y_out[W_Y-1]}}, y_out};

    vec_mul #(.C(C), .W_X(W_X), .W_K(W_K)) u_pe (
        .clk    (clk),
        .rst    (rst),
        .enable (pe_en),
        .x      (pe_x),
        .k      (pe_k),
        .y_out  (y_out)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (bus.s_last || trunc) ? DRAIN : FEED;
            FEED:    if (accept && (bus.s_last || trunc)) state_nx = DRAIN;
            DRAIN:   if (vld_sr == '0) state_nx = OUT;
            OUT:     if (res_valid && bus.m_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vld_sr    <= '0;
            count     <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
            res_y     <= '0;
        end else begin
            state <= state_nx;
            if (pe_en) vld_sr <= {vld_sr[PE_LATENCY-2:0], accept};
            if (accept) begin
                count <= count_nx;
                ovf   <= trunc;
            end
            // The pipe is empty in IDLE, so the first accept can clear the sum outright.
            if (state == IDLE && accept)
                acc <= '0;
            else if (pe_en && vld_sr[PE_LATENCY-1])
                acc <= acc + y_ext;
            if (state == DRAIN && state_nx == OUT) begin
                res_valid <= 1'b1;
                res_y     <= acc;
            end else if (state == OUT && bus.m_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign bus.m_valid    = res_valid;
    assign bus.m_y        = res_y;
    assign bus.m_overflow = ovf;

endmodule

// File: tb/tb_vec_dot_seq.sv
// tb/tb_vec_dot_seq.sv - scoreboard bench for vec_dot_seq against a lane-sum reference model
module tb_vec_dot_seq;
    import vec_pkg::*;

    localparam int C          = 4;
    localparam int W_X        = 8;
    localparam int W_K        = 8;
    localparam int MAX_CHUNKS = 16;
    localparam int PE_LATENCY = $clog2(C) + 1;
    localparam int W_A        = w_a(C, W_X, W_K, MAX_CHUNKS);

    localparam logic [31:0] X75 = 32'h03020107;
    localparam logic [31:0] K75 = 32'h01030309;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_dot_seq_if #(.C(C), .W_X(W_X), .W_K(W_K), .MAX_CHUNKS(MAX_CHUNKS)) bus ();

    vec_dot_seq #(.C(C), .W_X(W_X), .W_K(W_K), .MAX_CHUNKS(MAX_CHUNKS), .PE_LATENCY(PE_LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     total = 0;
    int     bad   = 0;
    longint exp_y [$];
    bit     exp_o [$];
    bit     rand_mready = 0;
    bit     prev_hold = 0;
    longint prev_y;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic longint dot(input logic [31:0] x, input logic [31:0] k);
        longint s = 0;
        for (int i = 0; i < C; i++) begin
            byte signed a, b;
            a = x[8*i +: 8];
            b = k[8*i +: 8];
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic longint dut_y();
        return longint'($signed(bus.m_y));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_chunk(input logic [31:0] x, input logic [31:0] k, input bit last, output int tries);
        bit rdy = 0;
        bit ok  = 0;
        tries = 0;
        bus.s_valid = 1'b1;
        bus.s_x     = x;
        bus.s_k     = k;
        bus.s_last  = last;
        while (!ok && tries < 200) begin
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk);
            #1;
            ok = rdy;
            tries++;
        end
        bus.s_valid = 1'b0;
        bus.s_x     = '0;
        bus.s_k     = '0;
        bus.s_last  = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic send_vec(input int n, input bit last, input bit rnd,
                            input logic [31:0] x0, input logic [31:0] k0, input int gap_max);
        longint sum = 0;
        int t;
        for (int c = 0; c < n; c++) begin
            logic [31:0] x = rnd ? $urandom : x0;
            logic [31:0] k = rnd ? $urandom : k0;
            sum += dot(x, k);
            send_chunk(x, k, last && (c == n-1), t);
            if (c != n-1 && gap_max > 0) idle($urandom_range(0, gap_max));
        end
        exp_y.push_back(sum);
        exp_o.push_back(!last);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_y.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        if (exp_y.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_y.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_mready) bus.m_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_y", dut_y(), prev_y);
            end
            if (bus.m_valid && bus.m_ready) begin
                prev_hold = 0;
                if (exp_y.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got m_y=%0d expected no result", dut_y());
                end else begin
                    check("m_y", dut_y(), exp_y.pop_front());
                    check("m_overflow", bus.m_overflow, exp_o.pop_front());
                end
            end else if (bus.m_valid) begin
                prev_hold = 1;
                prev_y    = dut_y();
            end else begin
                prev_hold = 0;
            end
        end
    end

    initial begin
        int t;
        int n;
        bus.s_valid = 1'b0;
        bus.s_x     = '0;
        bus.s_k     = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_y", dut_y(), 0);
        check("rst_m_overflow", bus.m_overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", bus.s_ready, 1);
        @(posedge clk);
        #1;

        // Single chunk with exact latency
        send_chunk(X75, K75, 1'b1, t);
        exp_y.push_back(75);
        exp_o.push_back(1'b0);
        for (int e = 1; e <= PE_LATENCY + 1; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("latency_m_valid", bus.m_valid, (e == PE_LATENCY + 1) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        wait_drain();

        // Two chunks with bubbles
        send_chunk(X75, K75, 1'b0, t);
        idle(3);
        send_chunk(X75, K75, 1'b1, t);
        exp_y.push_back(150);
        exp_o.push_back(1'b0);
        wait_drain();

        // Full-length vector of most-negative operands
        send_vec(16, 1'b1, 1'b0, 32'h80808080, 32'h80808080, 0);
        check("max_sum_model", exp_y[0], 1048576);
        wait_drain();

        // Truncation at MAX_CHUNKS with result held off
        bus.m_ready = 1'b0;
        send_vec(16, 1'b0, 1'b0, X75, K75, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("trunc_s_ready", bus.s_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        wait_drain();

        // Result backpressure then immediate next vector
        bus.m_ready = 1'b0;
        send_chunk(X75, K75, 1'b1, t);
        exp_y.push_back(75);
        exp_o.push_back(1'b0);
        n = 0;
        while (!bus.m_valid && n < 50) begin
            idle(1);
            n++;
        end
        check("bp_result_seen", bus.m_valid, 1);
        bus.s_valid = 1'b1;
        bus.s_x     = 32'hFFFFFFFF;
        bus.s_k     = 32'h01010101;
        bus.s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_s_ready", bus.s_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        send_chunk(32'hFFFFFFFF, 32'h01010101, 1'b1, t);
        check("bp_accept_cycle", t, 2);
        exp_y.push_back(-4);
        exp_o.push_back(1'b0);
        wait_drain();

        // Reset while two chunks are in flight
        send_chunk(X75, K75, 1'b0, t);
        send_chunk(X75, K75, 1'b1, t);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_s_ready", bus.s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_m_valid", bus.m_valid, 0);
        check("post_rst_m_y", dut_y(), 0);
        check("post_rst_m_overflow", bus.m_overflow, 0);
        check("post_rst_s_ready", bus.s_ready, 1);
        @(posedge clk);
        #1;
        send_chunk(X75, K75, 1'b1, t);
        exp_y.push_back(75);
        exp_o.push_back(1'b0);
        wait_drain();

        // Randomized vectors with random gaps and result backpressure
        rand_mready = 1;
        for (int v = 0; v < 30; v++) begin
            int  len = $urandom_range(1, MAX_CHUNKS);
            bit  lst = (len != MAX_CHUNKS) || ($urandom_range(0, 1) == 1);
            send_vec(len, lst, 1'b1, 32'h0, 32'h0, 2);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        wait_drain();
        rand_mready = 0;
        bus.m_ready = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
